// File: rtl/sr_latch_pkg.sv
// Shared types and constants for the NOR-latch bank sequencer.
package sr_latch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2,
        ST_CHECK = 2'd3
    } state_t;

    localparam logic OP_CLEAR = 1'b0;
    localparam logic OP_SET   = 1'b1;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sr_latch_bank_ctrl_sync2.sv
// Two-flop synchroniser for the asynchronous latch q feedback.
module sync2 #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/sr_latch_bank_ctrl.sv
// Sequencer driving timed single-hot set/reset pulses into a bank of NOR latches,
// then verifying the addressed latch through its synchronised q feedback.
module sr_latch_bank_ctrl
    import sr_latch_pkg::*;
#(
    parameter int unsigned N_LATCH   = 4,
    parameter int unsigned IDX_W     = $clog2(N_LATCH),
    parameter int unsigned PULSE_CYC = 2,
    parameter int unsigned GAP_CYC   = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [IDX_W-1:0]   req_idx,
    input  logic               req_op,
    output logic [N_LATCH-1:0] latch_set,
    output logic [N_LATCH-1:0] latch_reset,
    input  logic [N_LATCH-1:0] q_fb,
    output logic               done,
    output logic               err
);

    localparam int unsigned CNT_MAX = max_u(PULSE_CYC, GAP_CYC);
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int unsigned N_EXT   = 1 << IDX_W;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               op_q, op_d;
    logic [N_LATCH-1:0] set_d, rst_d;
    logic               ready_d, done_d, err_d;

    logic [N_LATCH-1:0] q_sync;
    logic [N_EXT-1:0]   q_ext;
    logic [N_LATCH-1:0] mask_req, mask_cur;
    logic               idx_illegal;

    sync2 #(.W(N_LATCH)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (q_fb),
        .q     (q_sync)
    );

    // Widened copy so an out-of-range index can never select past the vector.
    assign q_ext       = N_EXT'(q_sync);
    assign mask_req    = N_LATCH'(1) << req_idx;
    assign mask_cur    = N_LATCH'(1) << idx_q;
    assign idx_illegal = 32'(req_idx) >= N_LATCH;

    // Next-state and next-output logic; set and reset bits are mutually exclusive by op.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        op_d    = op_q;
        set_d   = '0;
        rst_d   = '0;
        ready_d = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                ready_d = 1'b1;
                if (req_valid && req_ready) begin
                    ready_d = 1'b0;
                    idx_d   = req_idx;
                    op_d    = req_op;
                    if (idx_illegal) begin
                        state_d = ST_CHECK;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else if (q_ext[req_idx] == req_op) begin
                        state_d = ST_CHECK;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_PULSE;
                        cnt_d   = CNT_W'(PULSE_CYC - 1);
                        if (req_op == OP_SET) set_d = mask_req;
                        else                  rst_d = mask_req;
                    end
                end
            end
            ST_PULSE: begin
                if (cnt_q == '0) begin
                    state_d = ST_GAP;
                    cnt_d   = CNT_W'(GAP_CYC - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (op_q == OP_SET) set_d = mask_cur;
                    else                rst_d = mask_cur;
                end
            end
            ST_GAP: begin
                if (cnt_q == '0) begin
                    state_d = ST_CHECK;
                    done_d  = 1'b1;
                    err_d   = (q_ext[idx_q] != op_q);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_CHECK: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Reset drops any in-flight command and holds the whole bank cleared.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            op_q        <= OP_CLEAR;
            latch_set   <= '0;
            latch_reset <= '1;
            req_ready   <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            op_q        <= op_d;
            latch_set   <= set_d;
            latch_reset <= rst_d;
            req_ready   <= ready_d;
            done        <= done_d;
            err         <= err_d;
        end
    end

endmodule
